decode_prefix_stream: RTL and testbench
=======================================

# decode_prefix_stream

Sequential, parametrised prefix decoder for the w80386dx front end. Consumes an instruction byte stream one byte per cycle and absorbs any run of prefix bytes into a registered prefix record. When the first non-prefix (opcode) byte arrives, it presents the record and the opcode byte to the opcode decoder through a valid/ready handshake. Unlike the fixed 4-byte combinational decoder, it handles prefix runs up to `MAX_PREFIX` long, resolves duplicates last-wins, counts prefixes, enforces a length limit and supports a default-size mode input.

## Interface
Parameters:
- `MAX_PREFIX`, default 14: maximum number of prefix bytes accepted per instruction (range 1..14).
- `CNT_W`, default `$clog2(MAX_PREFIX+1)`: width of the prefix counter.

Ports:
- `i_clk`, in, 1: clock. All state changes on the rising edge.
- `i_reset_n`, in, 1: reset, asynchronous, active-low.
- `i_flush`, in, 1: synchronous clear. Drops the record in progress.
- `i_default_32`, in, 1: code-segment default size; 1 = 32-bit.
- `i_byte_valid`, in, 1: stream byte valid.
- `i_byte`, in, 8: stream byte. Upstream holds it stable while `i_byte_valid && !o_byte_ready`.
- `o_byte_ready`, out, 1: byte consumed this cycle.
- `o_prefix_valid`, out, 1: record and opcode byte available.
- `i_prefix_ready`, in, 1: downstream accepts the record.
- `o_lock`, `o_rep_ne`, `o_rep_e`, out, 1 each: group 1 flags.
- `o_seg_override`, out, 1: a segment override is present.
- `o_seg_index`, out, 3: segment selector; ES=0, CS=1, SS=2, DS=3, FS=4, GS=5.
- `o_operand_size`, `o_address_size`, out, 1 each: 66h / 67h seen.
- `o_operand_32`, out, 1: effective operand size, `i_default_32 ^ o_operand_size`.
- `o_address_32`, out, 1: effective address size, `i_default_32 ^ o_address_size`.
- `o_prefix_count`, out, `CNT_W`: number of prefix bytes consumed.
- `o_error_repeat`, out, 1: more than one prefix from the same group.
- `o_error_limit`, out, 1: prefix run exceeded `MAX_PREFIX`.

## Operation
- Prefix set:
  - Group 1: F0 (lock), F2 (rep_ne), F3 (rep_e).
  - Group 2: 26, 2E, 36, 3E, 64, 65.
  - Group 3: 66.
  - Group 4: 67.
- FSM has two states, SCAN and HOLD. Reset state is SCAN.
- SCAN, prefix byte with count < `MAX_PREFIX`:
  - `o_byte_ready=1` and the byte is consumed.
  - Record updated and count incremented.
- Group 1 prefix: clears the other two group-1 flags and sets its own (last-wins).
- Group 2 prefix: sets `o_seg_override` and overwrites `o_seg_index` (last-wins).
- Groups 3 and 4: set their flag (sticky).
- Repeat error: if a group's present bit is already set when another prefix of that group arrives, set `o_error_repeat` (sticky).
- SCAN, non-prefix byte: `o_byte_ready=0`; next state HOLD.
- SCAN, prefix byte with count == `MAX_PREFIX`: `o_byte_ready=0`, set `o_error_limit`; next state HOLD.
- HOLD:
  - `o_prefix_valid=1` and `o_byte_ready = i_prefix_ready`.
  - The opcode byte (or the offending prefix) is consumed in the same cycle as the record handshake.
  - On handshake: clear the record and count to zero; next state SCAN.
- `i_byte_valid=0`: no state change.
- `i_flush`: wins over every other event. Clears the record, count and errors, forces SCAN, and forces `o_byte_ready=0` that cycle.
- Downstream treats `o_error_limit` as #GP and must flush. The byte consumed at that handshake is not a real opcode.

## Timing
- Reset values: all outputs 0; state SCAN; count 0. `o_operand_32` and `o_address_32` follow `i_default_32`.
- Each prefix costs 1 cycle. Record fields update on the edge after consumption.
- An opcode byte presented in cycle N gives `o_prefix_valid=1` from cycle N+1.
- Example: a run of k prefixes followed by the opcode gives valid k+1 cycles after the first byte.
- Throughput: one instruction every k+2 cycles, with no cross-instruction overlap.
- While `o_prefix_valid && !i_prefix_ready`, all record outputs are held stable.
- After the handshake edge, `o_prefix_valid` is 0 for at least one cycle.
- `o_byte_ready` is combinational from `i_byte`, `i_byte_valid`, state and `i_prefix_ready`. It never asserts when `i_byte_valid=0`.
- Reset asserted mid-HOLD: outputs drop asynchronously to their reset values. No handshake completes.

## Configuration
- Macro `DECODE_PREFIX_STRICT_GROUP_EN`.
- Defined: repeat detection is active and `o_error_repeat` behaves as specified.
- Undefined: `o_error_repeat` is tied to 0 and there is no detection logic. Last-wins resolution is unchanged.

## Test plan
- `i_default_32=1`, stream 66 67 F3 A5:
  - Three consumed bytes.
  - `o_prefix_valid` on the 4th cycle after the first byte.
  - Record: count=3, `o_rep_e=1`, `o_operand_32=0`, `o_address_32=0`.
  - A5 consumed at the handshake.
- Stream 2E 36 8B:
  - `o_seg_index=2`, `o_seg_override=1`.
  - `o_error_repeat=1` with the macro defined, 0 without.
- Stream F0 F2 AE: `o_rep_ne=1`, `o_lock=0`, count=2, `o_error_repeat=1` (strict build).
- `MAX_PREFIX=14`, fifteen 66 bytes then 90:
  - 14 consumed.
  - HOLD with `o_error_limit=1`, count=14.
  - The 15th 66 is consumed at the handshake.
- Stream 65 89 with `i_prefix_ready` low for 5 cycles:
  - Valid stays high, fields stable, `o_byte_ready=0`.
  - When ready rises: 89 consumed in 1 cycle, next cycle valid=0 and count=0.
- Interruptions:
  - Stream 26 66, then `i_flush` during a third prefix: record all 0, that byte not consumed.
  - Separately, `i_reset_n` low during HOLD: all outputs 0 immediately.

Source files
------------

// File: rtl/decode_prefix_stream_if.sv
`default_nettype none
// ============================================================================
//  decode_prefix_stream_if
//  Byte-stream and prefix-record bundle for decode_prefix_stream.
//  master: stream source / record consumer side.  slave: the decoder.
//  Revision: 1.0
// ============================================================================
interface decode_prefix_stream_if #(
  parameter int CNT_W = 4
);
  logic             i_flush;
  logic             i_default_32;
  logic             i_byte_valid;
  logic [7:0]       i_byte;
  logic             o_byte_ready;
  logic             o_prefix_valid;
  logic             i_prefix_ready;
  logic             o_lock;
  logic             o_rep_ne;
  logic             o_rep_e;
  logic             o_seg_override;
  logic [2:0]       o_seg_index;
  logic             o_operand_size;
  logic             o_address_size;
  logic             o_operand_32;
  logic             o_address_32;
  logic [CNT_W-1:0] o_prefix_count;
  logic             o_error_repeat;
  logic             o_error_limit;

  modport master (
    output i_flush, i_default_32, i_byte_valid, i_byte, i_prefix_ready,
    input  o_byte_ready, o_prefix_valid, o_lock, o_rep_ne, o_rep_e,
           o_seg_override, o_seg_index, o_operand_size, o_address_size,
           o_operand_32, o_address_32, o_prefix_count, o_error_repeat,
           o_error_limit
  );

  modport slave (
    input  i_flush, i_default_32, i_byte_valid, i_byte, i_prefix_ready,
    output o_byte_ready, o_prefix_valid, o_lock, o_rep_ne, o_rep_e,
           o_seg_override, o_seg_index, o_operand_size, o_address_size,
           o_operand_32, o_address_32, o_prefix_count, o_error_repeat,
           o_error_limit
  );
endinterface
`default_nettype wire

// File: rtl/decode_prefix_stream.sv
`default_nettype none
// ============================================================================
//  decode_prefix_stream
//  Sequential x86 prefix absorber: consumes one stream byte per cycle, folds
//  prefix bytes into a registered record and hands record + opcode byte to
//  the opcode decoder over a valid/ready handshake.
//  Optional macro DECODE_PREFIX_STRICT_GROUP_EN enables same-group repeat
//  detection (o_error_repeat); without it o_error_repeat is tied low.
//  Revision: 1.0
// ============================================================================
module decode_prefix_stream #(
  parameter int MAX_PREFIX = 14,
  parameter int CNT_W      = $clog2(MAX_PREFIX + 1)
) (
  input wire logic i_clk,
  input wire logic i_reset_n,
  decode_prefix_stream_if.slave bus
);

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(MAX_PREFIX);

  state_t           state;
  logic             lock;
  logic             rep_ne;
  logic             rep_e;
  logic             seg_override;
  logic [2:0]       seg_index;
  logic             operand_size;
  logic             address_size;
  logic [CNT_W-1:0] count;
  logic             error_limit;
  logic             error_repeat;

  logic             is_g1;
  logic             is_g2;
  logic             is_g3;
  logic             is_g4;
  logic             is_prefix;
  logic [2:0]       seg_code;
  logic             at_limit;
  logic             in_hold;
  logic             take_prefix;
  logic             stop_scan;
  logic             handshake;

  // Classify the current stream byte into prefix groups and segment code.
  always_comb begin
    is_g1    = 1'b0;
    is_g2    = 1'b0;
    seg_code = 3'd0;
    case (bus.i_byte)
      8'hF0, 8'hF2, 8'hF3: is_g1 = 1'b1;
      8'h26: begin is_g2 = 1'b1; seg_code = 3'd0; end
      8'h2E: begin is_g2 = 1'b1; seg_code = 3'd1; end
      8'h36: begin is_g2 = 1'b1; seg_code = 3'd2; end
      8'h3E: begin is_g2 = 1'b1; seg_code = 3'd3; end
      8'h64: begin is_g2 = 1'b1; seg_code = 3'd4; end
      8'h65: begin is_g2 = 1'b1; seg_code = 3'd5; end
      default: ;
    endcase
  end

  assign is_g3     = (bus.i_byte == 8'h66);
  assign is_g4     = (bus.i_byte == 8'h67);
  assign is_prefix = is_g1 | is_g2 | is_g3 | is_g4;
  assign at_limit  = (count == COUNT_MAX);
  assign in_hold   = (state == HOLD);

  // Flush masks every event, including the consume strobe, in its cycle.
  // The handshake also needs a valid byte: the opcode byte (or the offending
  // prefix) leaves the stream in the same cycle the record is taken.
  assign take_prefix = !bus.i_flush && bus.i_byte_valid && !in_hold && is_prefix && !at_limit;
  assign stop_scan   = !bus.i_flush && bus.i_byte_valid && !in_hold && (!is_prefix || at_limit);
  assign handshake   = !bus.i_flush && bus.i_byte_valid && in_hold && bus.i_prefix_ready;

`ifdef DECODE_PREFIX_STRICT_GROUP_EN
  logic dup_group;
  assign dup_group = (is_g1 && (lock | rep_ne | rep_e)) ||
                     (is_g2 && seg_override) ||
                     (is_g3 && operand_size) ||
                     (is_g4 && address_size);
`else
  assign error_repeat = 1'b0;
`endif

  // Scan/hold FSM together with the prefix record it builds.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= SCAN;
      lock         <= 1'b0;
      rep_ne       <= 1'b0;
      rep_e        <= 1'b0;
      seg_override <= 1'b0;
      seg_index    <= 3'd0;
      operand_size <= 1'b0;
      address_size <= 1'b0;
      count        <= '0;
      error_limit  <= 1'b0;
`ifdef DECODE_PREFIX_STRICT_GROUP_EN
      error_repeat <= 1'b0;
`endif
    end else if (bus.i_flush || handshake) begin
      state        <= SCAN;
      lock         <= 1'b0;
      rep_ne       <= 1'b0;
      rep_e        <= 1'b0;
      seg_override <= 1'b0;
      seg_index    <= 3'd0;
      operand_size <= 1'b0;
      address_size <= 1'b0;
      count        <= '0;
      error_limit  <= 1'b0;
`ifdef DECODE_PREFIX_STRICT_GROUP_EN
      error_repeat <= 1'b0;
`endif
    end else if (take_prefix) begin
      count <= count + 1'b1;
      if (is_g1) begin
        // Group 1 is mutually exclusive: the latest one replaces the others.
        lock   <= (bus.i_byte == 8'hF0);
        rep_ne <= (bus.i_byte == 8'hF2);
        rep_e  <= (bus.i_byte == 8'hF3);
      end
      if (is_g2) begin
        seg_override <= 1'b1;
        seg_index    <= seg_code;
      end
      if (is_g3) operand_size <= 1'b1;
      if (is_g4) address_size <= 1'b1;
`ifdef DECODE_PREFIX_STRICT_GROUP_EN
      if (dup_group) error_repeat <= 1'b1;
`endif
    end else if (stop_scan) begin
      state <= HOLD;
      // A prefix arriving with the record full terminates the run as a fault.
      if (is_prefix) error_limit <= 1'b1;
    end
  end

  assign bus.o_byte_ready   = take_prefix | handshake;
  assign bus.o_prefix_valid = in_hold;
  assign bus.o_lock         = lock;
  assign bus.o_rep_ne       = rep_ne;
  assign bus.o_rep_e        = rep_e;
  assign bus.o_seg_override = seg_override;
  assign bus.o_seg_index    = seg_index;
  assign bus.o_operand_size = operand_size;
  assign bus.o_address_size = address_size;
  assign bus.o_operand_32   = bus.i_default_32 ^ operand_size;
  assign bus.o_address_32   = bus.i_default_32 ^ address_size;
  assign bus.o_prefix_count = count;
  assign bus.o_error_repeat = error_repeat;
  assign bus.o_error_limit  = error_limit;

endmodule
`default_nettype wire

// File: tb/tb_decode_prefix_stream.sv
`default_nettype none
// ============================================================================
//  tb_decode_prefix_stream
//  Table-driven bench for decode_prefix_stream with a record scoreboard,
//  plus hand-written flush and mid-hold reset sequences.
//  Revision: 1.0
// ============================================================================
module tb_decode_prefix_stream;

  localparam int CNT_W = 4;

  // Record layout: lock rep_ne rep_e seg_ov seg_idx[3] opsz adsz op32 ad32
  //                err_rep err_lim count[4]
  typedef struct packed {
    logic [4:0]   n;
    logic [127:0] seq;
    logic         d32;
    logic [16:0]  exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [16:0] sb[$];
  vec_t vecs[$];

  decode_prefix_stream_if #(.CNT_W(CNT_W)) bus ();

  decode_prefix_stream #(.MAX_PREFIX(14), .CNT_W(CNT_W)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] mk(input logic lk, input logic rne, input logic re,
                                     input logic ov, input logic [2:0] idx,
                                     input logic os, input logic as_, input logic o32,
                                     input logic a32, input logic rep_strict,
                                     input logic lim, input logic [3:0] cnt);
    logic rep;
`ifdef DECODE_PREFIX_STRICT_GROUP_EN
    rep = rep_strict;
`else
    rep = 1'b0;
`endif
    return {lk, rne, re, ov, idx, os, as_, o32, a32, rep, lim, cnt};
  endfunction

  function automatic logic [16:0] cur_rec();
    return {bus.o_lock, bus.o_rep_ne, bus.o_rep_e, bus.o_seg_override, bus.o_seg_index,
            bus.o_operand_size, bus.o_address_size, bus.o_operand_32, bus.o_address_32,
            bus.o_error_repeat, bus.o_error_limit, bus.o_prefix_count};
  endfunction

  function automatic vec_t mkvec(input int n, input logic [127:0] seq, input logic d32,
                                 input logic [16:0] exp);
    vec_t v;
    v.n = 5'(n); v.seq = seq; v.d32 = d32; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compare the record at every handshake.
  always @(negedge clk) begin
    #3;
    if (rst_n && bus.o_prefix_valid && bus.i_prefix_ready && bus.i_byte_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_handshake", 32'd1, 32'd0);
      end else begin
        check("sb_record", {15'd0, cur_rec()}, {15'd0, sb.pop_front()});
      end
    end
  end

  // Stream one instruction; downstream ready rises ready_delay cycles after valid.
  task automatic send(input vec_t v, input int ready_delay, input string tag);
    int cyc, idx, j, first_valid, consumed, n;
    bit done;
    logic [16:0] snap;
    n = int'(v.n);
    sb.push_back(v.exp);
    bus.i_default_32 = v.d32;
    idx = 0; cyc = 0; first_valid = -1; consumed = 0; done = 1'b0; snap = '0;
    while (!done && cyc < 200) begin
      j = (idx < n) ? idx : n - 1;
      bus.i_byte_valid = 1'b1;
      bus.i_byte = v.seq[8*(n-1-j) +: 8];
      #1;
      if (bus.o_prefix_valid && first_valid < 0) begin
        first_valid = cyc;
        snap = cur_rec();
      end
      bus.i_prefix_ready = (first_valid >= 0) && (cyc - first_valid >= ready_delay);
      #1;
      if (first_valid >= 0 && !bus.i_prefix_ready) begin
        check({tag, " hold_ready_low"}, 32'(bus.o_byte_ready), 32'd0);
        check({tag, " hold_stable"}, {14'd0, bus.o_prefix_valid, cur_rec()},
              {14'd0, 1'b1, snap});
      end
      if (bus.o_byte_ready) begin
        if (first_valid >= 0) done = 1'b1;
        else begin idx++; consumed++; end
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_byte_valid = 1'b0;
    bus.i_prefix_ready = 1'b0;
    check({tag, " handshake_done"}, 32'(done), 32'd1);
    check({tag, " consumed_prefixes"}, consumed, n - 1);
    check({tag, " valid_cycle"}, first_valid, n);
    #1;
    check({tag, " after_handshake"}, {27'd0, bus.o_prefix_valid, bus.o_prefix_count},
          32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus.i_flush = 1'b0; bus.i_default_32 = 1'b1; bus.i_byte_valid = 1'b0;
    bus.i_byte = 8'h00; bus.i_prefix_ready = 1'b0;

    vecs.push_back(mkvec(4,  128'h6667F3A5, 1'b1, mk(0,0,1,0,3'd0,1,1,0,0,0,0,4'd3)));
    vecs.push_back(mkvec(3,  128'h2E368B,   1'b0, mk(0,0,0,1,3'd2,0,0,0,0,1,0,4'd2)));
    vecs.push_back(mkvec(3,  128'hF0F2AE,   1'b0, mk(0,1,0,0,3'd0,0,0,0,0,1,0,4'd2)));
    vecs.push_back(mkvec(1,  128'h90,       1'b1, mk(0,0,0,0,3'd0,0,0,1,1,0,0,4'd0)));
    vecs.push_back(mkvec(12, 128'h262E363E6465F0F3F266670F, 1'b0,
                         mk(0,1,0,1,3'd5,1,1,1,1,1,0,4'd11)));
    vecs.push_back(mkvec(4,  128'h64F366C3, 1'b0, mk(0,0,1,1,3'd4,1,0,1,0,0,0,4'd3)));
    vecs.push_back(mkvec(4,  128'hF0673E00, 1'b1, mk(1,0,0,1,3'd3,0,1,1,0,0,0,4'd3)));
    vecs.push_back(mkvec(3,  128'h666640,   1'b0, mk(0,0,0,0,3'd0,1,0,1,0,1,0,4'd2)));
    vecs.push_back(mkvec(15, {8'h00, {15{8'h66}}}, 1'b0,
                         mk(0,0,0,0,3'd0,1,0,1,0,1,1,4'd14)));

    // Reset state: effective sizes follow the default-size input.
    #12;
    check("reset_rec_d32", {15'd0, cur_rec()}, {15'd0, mk(0,0,0,0,3'd0,0,0,1,1,0,0,4'd0)});
    check("reset_valid", 32'(bus.o_prefix_valid), 32'd0);
    bus.i_default_32 = 1'b0;
    #1;
    check("reset_rec_d16", {15'd0, cur_rec()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Downstream stalls for five cycles with a segment-prefixed opcode.
    send(mkvec(2, 128'h6589, 1'b1, mk(0,0,0,1,3'd5,0,0,1,1,0,0,4'd1)), 5, "stall");

    // Flush arriving with a third prefix: record clears, byte not taken.
    bus.i_default_32 = 1'b0; bus.i_prefix_ready = 1'b0;
    bus.i_byte_valid = 1'b1; bus.i_byte = 8'h26;
    #1 check("flush_b0_ready", 32'(bus.o_byte_ready), 32'd1);
    @(negedge clk); bus.i_byte = 8'h66;
    #1 check("flush_b1_ready", 32'(bus.o_byte_ready), 32'd1);
    @(negedge clk); bus.i_byte = 8'hF3; bus.i_flush = 1'b1;
    #1;
    check("flush_pre_rec", {15'd0, cur_rec()}, {15'd0, mk(0,0,0,1,3'd0,1,0,1,0,0,0,4'd2)});
    check("flush_ready_low", 32'(bus.o_byte_ready), 32'd0);
    @(negedge clk); bus.i_flush = 1'b0; bus.i_byte_valid = 1'b0;
    #1 check("flush_cleared", {14'd0, bus.o_prefix_valid, cur_rec()}, 32'd0);
    @(negedge clk);

    // Reset asserted while holding a record: outputs drop without a clock.
    bus.i_byte_valid = 1'b1; bus.i_byte = 8'h65;
    @(negedge clk); bus.i_byte = 8'h89;
    @(negedge clk);
    #1;
    check("rst_hold_valid", 32'(bus.o_prefix_valid), 32'd1);
    check("rst_hold_rec", {15'd0, cur_rec()}, {15'd0, mk(0,0,0,1,3'd5,0,0,0,0,0,0,4'd1)});
    #1 rst_n = 1'b0;
    #1 check("rst_async_clear", {14'd0, bus.o_prefix_valid, cur_rec()}, 32'd0);
    @(negedge clk); bus.i_byte_valid = 1'b0; rst_n = 1'b1;
    #1 check("rst_after_release", {14'd0, bus.o_prefix_valid, cur_rec()}, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
